// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, the NOP encoding and the sequencer state codes.
package cpu_pkg;
    localparam int CPU_INST_W = 32;
    localparam logic [CPU_INST_W-1:0] CPU_NOP = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/seq_inst_mem.sv
// Instruction store: register file with synchronous write and asynchronous read.
module seq_inst_mem #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data
);
    logic [INST_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read sees the pre-edge contents, giving read-before-write.
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: issues a one-shot prologue followed by a repeated loop body from a
// host-loaded instruction store, one registered instruction per cycle.
module inst_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W = 4,
    parameter int                INST_W = CPU_INST_W,
    parameter logic [INST_W-1:0] NOP    = CPU_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [ADDR_W:0]   body_start,
    input  logic [7:0]        repeat_count,
    input  logic              abort,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    seq_state_t        state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [7:0]        passes, passes_n;
    logic [ADDR_W:0]   len_q, body_q;
    logic [ADDR_W:0]   pc_inc;
    logic              cfg_load;
    logic [INST_W-1:0] rd_data, inst_n;

    seq_inst_mem #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && (state == SEQ_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_n),
        .rd_data (rd_data)
    );

    // Widened so a full-depth program terminates instead of wrapping pc.
    assign pc_inc = {1'b0, pc} + (ADDR_W+1)'(1);

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        passes_n = passes;
        cfg_load = 1'b0;
        case (state)
            SEQ_IDLE: begin
                pc_n = '0;
                if (start) begin
                    cfg_load = 1'b1;
                    passes_n = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                    state_n  = (prog_len == '0) ? SEQ_DONE : SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (abort) begin
                    state_n = SEQ_IDLE;
                    pc_n    = '0;
                end else if (pc_inc < len_q) begin
                    pc_n = pc_inc[ADDR_W-1:0];
                end else if ((body_q < len_q) && (passes > 8'd1)) begin
                    pc_n     = body_q[ADDR_W-1:0];
                    passes_n = passes - 8'd1;
                end else begin
                    state_n = SEQ_DONE;
                    pc_n    = '0;
                end
            end
            default: begin
                state_n = SEQ_IDLE;
                pc_n    = '0;
            end
        endcase
    end

    // The store is addressed by the next pc, so the word lands in inst_out with the pc update.
    assign inst_n = (state_n == SEQ_RUN) ? rd_data : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEQ_IDLE;
            pc       <= '0;
            passes   <= 8'd0;
            inst_out <= NOP;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            passes   <= passes_n;
            inst_out <= inst_n;
            busy     <= (state_n == SEQ_RUN);
            done     <= (state_n == SEQ_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_load) begin
            len_q  <= prog_len;
            body_q <= body_start;
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: expected word streams come from an address-list model.
module tb_inst_sequencer;
    import cpu_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst, wr_en, start, abort;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   prog_len, body_start;
    logic [7:0]        repeat_count;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] pc;
    logic              busy, done;

    always #5 clk = ~clk;

    inst_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .prog_len     (prog_len),
        .body_start   (body_start),
        .repeat_count (repeat_count),
        .abort        (abort),
        .inst_out     (inst_out),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        bit          is_done;
        logic [31:0] inst;
        logic [3:0]  addr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    int          addrs[$];
    int          errors = 0;
    int          checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Address order of the issued words, straight from the prologue/body/pass rule.
    task automatic build(input int len, input int body, input int rep);
        int passes;
        addrs.delete();
        passes = (rep == 0) ? 1 : rep;
        if (body >= len) begin
            for (int a = 0; a < len; a++) addrs.push_back(a);
        end else begin
            for (int a = 0; a < body; a++) addrs.push_back(a);
            for (int p = 0; p < passes; p++)
                for (int a = body; a < len; a++) addrs.push_back(a);
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    // cut: 0 none, 1 abort, 2 reset after k words (k=0 picks one). wmode: 0 none, 1 random, 2 DEADBEEF@1.
    task automatic run_prog(input int len, input int body, input int rep, input int cut_req,
                            input int k_req, input int wmode, input bit wr_same,
                            input logic [31:0] same_data);
        int   n, k, cut, iters;
        exp_t e;
        build(len, body, rep);
        n   = addrs.size();
        cut = (n >= 2) ? cut_req : 0;
        k   = k_req;
        if (cut != 0 && (k < 1 || k >= n)) k = 1 + int'($urandom % 32'(n - 1));
        for (int i = 0; i < ((cut != 0) ? k : n); i++) begin
            e.is_done = 1'b0;
            e.inst    = model[addrs[i]];
            e.addr    = 4'(addrs[i]);
            q.push_back(e);
        end
        if (cut == 0) begin
            e.is_done = 1'b1; e.inst = CPU_NOP; e.addr = 4'd0;
            q.push_back(e);
        end
        prog_len = 5'(len); body_start = 5'(body); repeat_count = 8'(rep);
        start = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = same_data;
        end
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (wr_same) model[0] = same_data;
        iters = (cut != 0) ? k - 1 : n + 1;
        for (int j = 0; j < iters; j++) begin
            if (wmode == 1) begin
                wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = $urandom;
            end else if (wmode == 2) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hDEADBEEF;
            end
            // config changes mid-run must have no effect
            prog_len = 5'($urandom); body_start = 5'($urandom); repeat_count = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        if (cut != 0) begin
            if (cut == 1) abort = 1'b1; else rst = 1'b1;
            tick();
            abort = 1'b0; rst = 1'b0;
            chk("cut_busy", 32'(busy), 32'd0);
            chk("cut_inst", inst_out, CPU_NOP);
            chk("cut_done", 32'(done), 32'd0);
            if (cut == 2) chk("rst_pc", 32'(pc), 32'd0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_word: got inst=%h pc=%0d, expected no word", inst_out, pc);
            end else begin
                e = q.pop_front();
                if (e.is_done || inst_out !== e.inst || pc !== e.addr) begin
                    errors++;
                    $display("FAIL word: got inst=%h pc=%0d, expected %s inst=%h pc=%0d",
                             inst_out, pc, e.is_done ? "done" : "word", e.inst, e.addr);
                end
            end
        end else begin
            chk("idle_nop", inst_out, CPU_NOP);
        end
        if (done !== 1'b0) begin
            checks++;
            if (q.size() == 0 || !q[0].is_done) begin
                errors++;
                $display("FAIL done_pulse: got done=%b, expected no done (pending=%0d)", done, q.size());
            end else begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        wr_addr = '0; wr_data = '0; prog_len = '0; body_start = '0; repeat_count = '0;
        tick(); tick();
        chk("reset_inst", inst_out, CPU_NOP);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) write_word(a, $urandom);

        write_word(0, 32'h20010001);
        write_word(1, 32'h20020001);
        write_word(2, 32'h00220820);
        write_word(3, 32'h00221020);
        run_prog(4, 2, 5, 0, 0, 0, 1'b0, 32'h0);       // fibonacci loop, 12 words
        run_prog(0, 0, 3, 0, 0, 0, 1'b0, 32'h0);       // empty program
        run_prog(6, 6, 9, 0, 0, 0, 1'b0, 32'h0);       // body beyond end: single pass
        run_prog(4, 2, 5, 1, 3, 0, 1'b0, 32'h0);       // abort at pc=2
        run_prog(4, 2, 5, 0, 0, 0, 1'b0, 32'h0);
        run_prog(4, 2, 5, 0, 0, 2, 1'b0, 32'h0);       // writes in RUN dropped
        run_prog(4, 2, 5, 0, 0, 0, 1'b0, 32'h0);
        run_prog(4, 2, 5, 2, 4, 0, 1'b0, 32'h0);       // reset at pc=3
        run_prog(4, 2, 5, 0, 0, 0, 1'b0, 32'h0);
        run_prog(4, 2, 2, 0, 0, 0, 1'b1, 32'hCAFE0001); // start + write to addr 0
        run_prog(4, 2, 2, 0, 0, 0, 1'b0, 32'h0);
        run_prog(16, 0, 2, 0, 0, 0, 1'b0, 32'h0);
        run_prog(16, 15, 3, 0, 0, 0, 1'b0, 32'h0);
        run_prog(5, 0, 0, 0, 0, 0, 1'b0, 32'h0);
        run_prog(3, 17, 4, 0, 0, 0, 1'b0, 32'h0);

        for (int it = 0; it < 40; it++) begin
            int len, body, rep, cut;
            if ($urandom_range(0, 2) == 0) write_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            len  = int'($urandom_range(0, 16));
            body = int'($urandom_range(0, 17));
            rep  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
            cut  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_prog(len, body, rep, cut, 0, 1, 1'($urandom_range(0, 4) == 0), $urandom);
        end

        tick(); tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
